// File: rtl/tdc_window_decoder_if.sv
// Window-result handshake between the TDC decoder and the CPA trace capture logic.
// The producer holds acc_out/min_out/max_out stable while acc_valid_out is high.
interface tdc_window_decoder_if #(
    parameter int OUTPUT_WIDTH = 7,
    parameter int ACC_WIDTH    = OUTPUT_WIDTH + 8
);
    logic [ACC_WIDTH-1:0]    acc_out;
    logic [OUTPUT_WIDTH-1:0] min_out;
    logic [OUTPUT_WIDTH-1:0] max_out;
    logic                    acc_valid_out;
    logic                    acc_ready_in;

    modport master (
        output acc_out,
        output min_out,
        output max_out,
        output acc_valid_out,
        input  acc_ready_in
    );

    modport slave (
        input  acc_out,
        input  min_out,
        input  max_out,
        input  acc_valid_out,
        output acc_ready_in
    );
endinterface

// File: rtl/tdc_window_decoder.sv
// Delay-line sensor decoder: per-sample thermometer code conversion plus
// power-of-two window sum/min/max with a valid/ready result port and sticky overrun.
module tdc_window_decoder #(
    parameter int INPUT_LEN    = 64,
    parameter int OUTPUT_WIDTH = 7,
    parameter int ACC_WIDTH    = OUTPUT_WIDTH + 8
) (
    input  logic                    clkin,
    input  logic                    rstin,
    input  logic [INPUT_LEN-1:0]    sensein,
    input  logic                    enable_in,
    input  logic [1:0]              mode_in,
    input  logic [3:0]              acc_len_in,
    output logic [OUTPUT_WIDTH-1:0] sample_out,
    output logic                    sample_valid_out,
    output logic                    overrun_out,
    input  logic                    clear_overrun_in,
    tdc_window_decoder_if.master    res
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    function automatic logic [OUTPUT_WIDTH-1:0] code_msb(input logic [INPUT_LEN-1:0] w);
        logic [OUTPUT_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < INPUT_LEN; i++)
            if (w[i]) r = OUTPUT_WIDTH'(i + 1);
        return r;
    endfunction

    function automatic logic [OUTPUT_WIDTH-1:0] code_popcount(input logic [INPUT_LEN-1:0] w);
        logic [OUTPUT_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < INPUT_LEN; i++)
            r = r + {{(OUTPUT_WIDTH-1){1'b0}}, w[i]};
        return r;
    endfunction

    function automatic logic [OUTPUT_WIDTH-1:0] code_run(input logic [INPUT_LEN-1:0] w);
        logic [OUTPUT_WIDTH-1:0] r;
        logic                    run;
        r   = '0;
        run = 1'b1;
        for (int i = 0; i < INPUT_LEN; i++) begin
            run = run & w[i];
            if (run) r = OUTPUT_WIDTH'(i + 1);
        end
        return r;
    endfunction

    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        return (l > 4'd8) ? 4'd8 : l;
    endfunction

    state_t                  state;
    logic [INPUT_LEN-1:0]    sensebuf_p0;
    logic                    vld_p0;
    logic                    win_p0;
    logic                    win_p1;
    logic [1:0]              mode_q;
    logic [3:0]              len_q;
    logic [8:0]              cnt_q;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic [OUTPUT_WIDTH-1:0] min_q;
    logic [OUTPUT_WIDTH-1:0] max_q;
    logic [ACC_WIDTH-1:0]    res_acc;
    logic [OUTPUT_WIDTH-1:0] res_min;
    logic [OUTPUT_WIDTH-1:0] res_max;
    logic                    res_vld;

    logic [OUTPUT_WIDTH-1:0] code_p0;
    logic [8:0]              win_last;
    logic                    accept;
    logic                    complete;
    logic [ACC_WIDTH-1:0]    sum_nxt;
    logic [OUTPUT_WIDTH-1:0] min_nxt;
    logic [OUTPUT_WIDTH-1:0] max_nxt;

    always_comb begin
        case (mode_q)
            2'd1:    code_p0 = code_popcount(sensebuf_p0);
            2'd2:    code_p0 = code_run(sensebuf_p0);
            default: code_p0 = code_msb(sensebuf_p0);
        endcase
    end

    // win_p1 marks samples that belong to the current window; samples captured
    // while draining are never accumulated.
    assign win_last = (9'd1 << len_q) - 9'd1;
    assign accept   = (state != IDLE) && sample_valid_out && win_p1;
    assign complete = accept && (cnt_q == win_last);
    assign sum_nxt  = acc_q + ACC_WIDTH'(sample_out);
    assign min_nxt  = (sample_out < min_q) ? sample_out : min_q;
    assign max_nxt  = (sample_out > max_q) ? sample_out : max_q;

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            state            <= IDLE;
            sensebuf_p0      <= '0;
            vld_p0           <= 1'b0;
            win_p0           <= 1'b0;
            win_p1           <= 1'b0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            mode_q           <= 2'd0;
            len_q            <= 4'd0;
            cnt_q            <= 9'd0;
            acc_q            <= '0;
            min_q            <= '1;
            max_q            <= '0;
            res_acc          <= '0;
            res_min          <= '0;
            res_max          <= '0;
            res_vld          <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            // stage 1: capture
            vld_p0 <= enable_in;
            win_p0 <= enable_in && (state != DRAIN);
            if (enable_in) sensebuf_p0 <= sensein;

            // stage 2: code
            sample_valid_out <= vld_p0;
            win_p1           <= win_p0;
            if (vld_p0) sample_out <= code_p0;

            // window accumulation
            case (state)
                IDLE: begin
                    if (enable_in) begin
                        mode_q <= mode_in;
                        len_q  <= clamp_len(acc_len_in);
                        acc_q  <= '0;
                        cnt_q  <= 9'd0;
                        min_q  <= '1;
                        max_q  <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM, DRAIN: begin
                    if (complete) begin
                        mode_q <= mode_in;
                        len_q  <= clamp_len(acc_len_in);
                        acc_q  <= '0;
                        cnt_q  <= 9'd0;
                        min_q  <= '1;
                        max_q  <= '0;
                    end else if (accept) begin
                        acc_q <= sum_nxt;
                        cnt_q <= cnt_q + 9'd1;
                        min_q <= min_nxt;
                        max_q <= max_nxt;
                    end
                    if (state == DRAIN)   state <= IDLE;
                    else if (!enable_in)  state <= DRAIN;
                end
                default: state <= IDLE;
            endcase

            // result handshake
            if (complete) begin
                if (!res_vld || res.acc_ready_in) begin
                    res_acc <= sum_nxt;
                    res_min <= min_nxt;
                    res_max <= max_nxt;
                    res_vld <= 1'b1;
                end
            end else if (res_vld && res.acc_ready_in) begin
                res_vld <= 1'b0;
            end

            if (complete && res_vld && !res.acc_ready_in) overrun_out <= 1'b1;
            else if (clear_overrun_in)                    overrun_out <= 1'b0;
        end
    end

    assign res.acc_out       = res_acc;
    assign res.min_out       = res_min;
    assign res.max_out       = res_max;
    assign res.acc_valid_out = res_vld;

endmodule
